// File: rtl/hist_reader_if.sv
// Histogram read port plus the bin stream to the display/UART back end.
// master = hist_reader; slave = the histogram source and stream consumer.
interface hist_reader_if #(
  parameter int unsigned VALUE_BITS = 16,
  parameter int unsigned BAR_BITS   = 8
);
  logic                  hist_switch;
  logic [7:0]            hist_address;
  logic [VALUE_BITS-1:0] hist_value;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_bin;
  logic [VALUE_BITS-1:0] out_count;
  logic [BAR_BITS-1:0]   out_bar;

  modport master (
    output hist_switch, hist_address, out_valid, out_bin, out_count, out_bar,
    input  hist_value, out_ready
  );

  modport slave (
    input  hist_switch, hist_address, out_valid, out_bin, out_count, out_bar,
    output hist_value, out_ready
  );
endinterface

// File: rtl/hist_reader.sv
// Histogram read-out client: pass 1 finds peak bin and total, pass 2 streams
// every bin as {bin, count, normalized bar} over valid/ready.
module hist_reader #(
  parameter int unsigned BINS       = 256,
  parameter int unsigned VALUE_BITS = 16,
  parameter int unsigned BAR_BITS   = 8
) (
  input  logic                  hist_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hist_sel,
  hist_reader_if.master         hist,
  output logic                  busy,
  output logic                  done,
  output logic [VALUE_BITS-1:0] max_value,
  output logic [7:0]            max_bin,
  output logic [23:0]           total,
  output logic [3:0]            shift_amt
);

  localparam logic [7:0] LAST_BIN = 8'(BINS - 1);

  typedef enum logic [2:0] {IDLE, SCAN, STREAM_RD, STREAM_OUT, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] bit_len;

  always_ff @(posedge hist_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (hist.hist_address == LAST_BIN) state_d = STREAM_RD;
      end
      STREAM_RD: begin
        busy    = 1'b1;
        state_d = STREAM_OUT;
      end
      STREAM_OUT: begin
        busy = 1'b1;
        if (hist.out_ready)
          state_d = (hist.out_bin == LAST_BIN) ? DONE : STREAM_RD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Normalization shift keeps the peak within BAR_BITS; derived from the held peak.
  always_comb begin
    bit_len = '0;
    for (int unsigned i = 0; i < VALUE_BITS; i++)
      if (max_value[i]) bit_len = 5'(i + 1);
    shift_amt = (bit_len > 5'(BAR_BITS)) ? 4'(bit_len - 5'(BAR_BITS)) : '0;
  end

  always_ff @(posedge hist_clk) begin
    if (reset) begin
      hist.hist_switch  <= 1'b0;
      hist.hist_address <= '0;
      hist.out_valid    <= 1'b0;
      hist.out_bin      <= '0;
      hist.out_count    <= '0;
      hist.out_bar      <= '0;
      max_value         <= '0;
      max_bin           <= '0;
      total             <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          hist.hist_switch  <= hist_sel;
          hist.hist_address <= '0;
          max_value         <= '0;
          max_bin           <= '0;
          total             <= '0;
        end
        SCAN: begin
          // hist_value is combinational on the current address, so the bin
          // sampled at this edge is the one hist_address presents now.
          total <= total + 24'(hist.hist_value);
          if (hist.hist_value > max_value) begin
            max_value <= hist.hist_value;
            max_bin   <= hist.hist_address;
          end
          if (hist.hist_address == LAST_BIN) hist.hist_address <= '0;
          else                               hist.hist_address <= hist.hist_address + 8'd1;
        end
        STREAM_RD: begin
          hist.out_bin   <= hist.hist_address;
          hist.out_count <= hist.hist_value;
          hist.out_bar   <= BAR_BITS'(hist.hist_value >> shift_amt);
          hist.out_valid <= 1'b1;
        end
        STREAM_OUT: if (hist.out_ready) begin
          hist.out_valid <= 1'b0;
          if (hist.out_bin != LAST_BIN) hist.hist_address <= hist.hist_address + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_reader.sv
// Randomized bench for hist_reader: a behavioural model of the selected
// histogram predicts peak, total, shift and every streamed beat.
module tb_hist_reader;

  logic        hist_clk = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic        hist_sel = 1'b0;
  logic        busy, done;
  logic [15:0] max_value;
  logic [7:0]  max_bin;
  logic [23:0] total;
  logic [3:0]  shift_amt;

  hist_reader_if #(.VALUE_BITS(16), .BAR_BITS(8)) bus ();

  logic [15:0] orig_mem [256];
  logic [15:0] eq_mem   [256];

  assign bus.hist_value = bus.hist_switch ? orig_mem[bus.hist_address] : eq_mem[bus.hist_address];

  hist_reader #(.BINS(256), .VALUE_BITS(16), .BAR_BITS(8)) dut (
    .hist_clk  (hist_clk),
    .reset     (reset),
    .start     (start),
    .hist_sel  (hist_sel),
    .hist      (bus),
    .busy      (busy),
    .done      (done),
    .max_value (max_value),
    .max_bin   (max_bin),
    .total     (total),
    .shift_amt (shift_amt)
  );

  initial forever #5 hist_clk = ~hist_clk;

  int cyc = 0;
  always @(posedge hist_clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model results for the histogram selected at start
  logic        exp_sw;
  int          exp_max, exp_bin, exp_total, exp_shift;

  function automatic int sel_val(input int i);
    return exp_sw ? int'(orig_mem[i]) : int'(eq_mem[i]);
  endfunction

  task automatic compute_model();
    int bl;
    exp_max = 0; exp_bin = 0; exp_total = 0;
    for (int i = 0; i < 256; i++) begin
      exp_total += sel_val(i);
      if (sel_val(i) > exp_max) begin
        exp_max = sel_val(i);
        exp_bin = i;
      end
    end
    bl = $clog2(exp_max + 1);
    exp_shift = (bl > 8) ? bl - 8 : 0;
  endtask

  // Scoreboard state shared with the compare process
  bit          active = 0;
  bit          timing_chk = 0;
  bit          first_seen;
  int          exp_idx, hs, dones, start_cyc;
  bit          hold_prev;
  logic [7:0]  hold_bin, hold_bar;
  logic [15:0] hold_count;
  int          got_bar [256];

  task automatic arm(input logic sel);
    exp_sw     = sel;
    compute_model();
    exp_idx    = 0;
    hs         = 0;
    dones      = 0;
    first_seen = 0;
    hold_prev  = 0;
    for (int i = 0; i < 256; i++) got_bar[i] = -1;
    active     = 1;
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = stall 10 cycles on bin 3
  int ready_mode = 0;
  int stall_cnt  = 0;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge hist_clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.out_valid && bus.out_bin == 8'd3 && stall_cnt < 10) begin
            bus.out_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Compare process: every cycle of an armed run
  initial begin
    forever begin
      @(negedge hist_clk);
      if (active && !reset) begin
        if (busy) chk("hist_switch", 32'(bus.hist_switch), 32'(exp_sw));
        if (hold_prev) begin
          chk("hold_valid", 32'(bus.out_valid), 32'd1);
          if (bus.out_valid) begin
            chk("hold_bin",   32'(bus.out_bin),   32'(hold_bin));
            chk("hold_count", 32'(bus.out_count), 32'(hold_count));
            chk("hold_bar",   32'(bus.out_bar),   32'(hold_bar));
          end
        end
        hold_prev = 0;
        if (bus.out_valid) begin
          if (exp_idx > 255) begin
            chk("extra_beat", 32'(exp_idx), 32'd255);
          end else begin
            chk("out_bin",   32'(bus.out_bin),   32'(exp_idx));
            chk("out_count", 32'(bus.out_count), 32'(sel_val(exp_idx)));
            chk("out_bar",   32'(bus.out_bar),   32'(sel_val(exp_idx) >> exp_shift));
            got_bar[exp_idx] = int'(bus.out_bar);
            if (!first_seen) begin
              first_seen = 1;
              chk("first_valid_latency", 32'(cyc - start_cyc), 32'd257);
            end
            if (bus.out_ready) begin
              hs++;
              exp_idx++;
            end else begin
              hold_prev  = 1;
              hold_bin   = bus.out_bin;
              hold_count = bus.out_count;
              hold_bar   = bus.out_bar;
            end
          end
        end
        if (done) begin
          dones++;
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("hs_at_done",   32'(hs),   32'd256);
          if (timing_chk) chk("done_latency", 32'(cyc - start_cyc), 32'd768);
        end
      end
    end
  end

  task automatic pulse_start(input logic sel);
    @(negedge hist_clk);
    hist_sel = sel;
    start    = 1'b1;
    @(negedge hist_clk);
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_scan(input logic sel, input int mode, input int restart_at, input string tag);
    ready_mode = mode;
    stall_cnt  = 0;
    timing_chk = (mode == 0);
    arm(sel);
    pulse_start(sel);
    for (int c = 0; c < 4000 && dones == 0; c++) begin
      @(negedge hist_clk);
      if (restart_at != 0 && c == restart_at) begin
        hist_sel = ~sel;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(dones), 32'd1);
    repeat (3) @(negedge hist_clk);
    chk({tag, "_single_done"}, 32'(dones), 32'd1);
    chk({tag, "_handshakes"},  32'(hs),    32'd256);
    chk({tag, "_busy_after"},  32'(busy),  32'd0);
    chk({tag, "_max_value"},   32'(max_value), 32'(exp_max));
    chk({tag, "_max_bin"},     32'(max_bin),   32'(exp_bin));
    chk({tag, "_total"},       32'(total),     32'(exp_total));
    chk({tag, "_shift_amt"},   32'(shift_amt), 32'(exp_shift));
    active = 0;
  endtask

  task automatic fill_random(input int mag);
    for (int i = 0; i < 256; i++) begin
      orig_mem[i] = 16'($urandom & ((1 << mag) - 1));
      eq_mem[i]   = 16'($urandom & ((1 << mag) - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dseen;
    bit bar_ok;
    repeat (3) @(negedge hist_clk);
    chk("rst_valid",   32'(bus.out_valid),    32'd0);
    chk("rst_busy",    32'(busy),             32'd0);
    chk("rst_done",    32'(done),             32'd0);
    chk("rst_addr",    32'(bus.hist_address), 32'd0);
    chk("rst_switch",  32'(bus.hist_switch),  32'd0);
    chk("rst_max",     32'(max_value),        32'd0);
    chk("rst_total",   32'(total),            32'd0);
    chk("rst_shift",   32'(shift_amt),        32'd0);
    reset = 1'b0;

    // All bins zero
    for (int i = 0; i < 256; i++) begin orig_mem[i] = '0; eq_mem[i] = '0; end
    run_scan(1'b0, 0, 0, "zero");
    chk("zero_lit_total", 32'(total), 32'd0);
    chk("zero_lit_shift", 32'(shift_amt), 32'd0);

    // Ramp: bin k = 4k on the original histogram, noise on the equalized one
    for (int i = 0; i < 256; i++) begin
      orig_mem[i] = 16'(4 * i);
      eq_mem[i]   = 16'($urandom);
    end
    run_scan(1'b1, 0, 0, "ramp");
    chk("ramp_lit_max",   32'(max_value), 32'd1020);
    chk("ramp_lit_bin",   32'(max_bin),   32'd255);
    chk("ramp_lit_shift", 32'(shift_amt), 32'd2);
    chk("ramp_lit_total", 32'(total),     32'd130560);
    bar_ok = 1;
    for (int i = 0; i < 256; i++) if (got_bar[i] != i) bar_ok = 0;
    chk("ramp_lit_bar_eq_bin", 32'(bar_ok), 32'd1);

    // Two equal peaks with random back-pressure
    for (int i = 0; i < 256; i++) begin
      eq_mem[i]   = 16'd1;
      orig_mem[i] = 16'($urandom);
    end
    eq_mem[10]  = 16'd5000;
    eq_mem[200] = 16'd5000;
    run_scan(1'b0, 1, 0, "tie");
    chk("tie_lit_bin",   32'(max_bin),   32'd10);
    chk("tie_lit_shift", 32'(shift_amt), 32'd5);
    chk("tie_lit_total", 32'(total),     32'd10254);
    chk("tie_lit_bar10", 32'(got_bar[10]),  32'd156);
    chk("tie_lit_bar200",32'(got_bar[200]), 32'd156);
    chk("tie_lit_bar5",  32'(got_bar[5]),   32'd0);

    // Back-pressure on bin 3
    fill_random(16);
    run_scan(1'b1, 2, 0, "stall");
    chk("stall_cycles", 32'(stall_cnt), 32'd10);

    // Reset while bin 100 is valid
    fill_random(12);
    ready_mode = 0;
    timing_chk = 0;
    arm(1'b0);
    pulse_start(1'b0);
    for (int c = 0; c < 2000; c++) begin
      @(negedge hist_clk);
      if (bus.out_valid && bus.out_bin == 8'd100) break;
    end
    chk("reach_bin100", 32'(bus.out_bin), 32'd100);
    active = 0;
    reset  = 1'b1;
    @(negedge hist_clk);
    reset = 1'b0;
    chk("abort_valid", 32'(bus.out_valid),    32'd0);
    chk("abort_busy",  32'(busy),             32'd0);
    chk("abort_addr",  32'(bus.hist_address), 32'd0);
    dseen = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy) dseen++;
      @(negedge hist_clk);
    end
    chk("abort_no_done", 32'(dseen), 32'd0);
    run_scan(1'b0, 0, 0, "rerun");

    // Re-start and toggled select mid-run are ignored
    fill_random(16);
    run_scan(1'b1, 0, 300, "restart");

    // Random histograms, selects and back-pressure
    for (int r = 0; r < 4; r++) begin
      fill_random($urandom_range(1, 16));
      run_scan(1'($urandom_range(0, 1)), 1, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
